// File: rtl/expose_sequencer_pkg.sv
// expose_pkg: shared state type, datapath widths and the watchdog limit helper
// for the exposure frame sequencer.
package expose_pkg;

    localparam int EXP_W  = 6;
    localparam int RAMP_W = 8;
    localparam int ROW_W  = 4;
    localparam int WD_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ,
        S_DONE
    } seq_state_t;

    // Watchdog counts from 0 on the first EXPOSE cycle, so the last allowed
    // cycle carries the value exposure + margin - 1.
    function automatic logic [WD_W-1:0] wd_limit(input logic [EXP_W-1:0] exp_cycles,
                                                 input int margin);
        return WD_W'(exp_cycles) + WD_W'(margin) - WD_W'(1);
    endfunction

endpackage

// File: rtl/expose_sequencer_counter.sv
// seq_counter: loadable up-counter with a terminal-count flag, used for the
// erase, watchdog, ramp and row counters of the sequencer.
module seq_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : en_i ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = cnt_q == tc_val_i;

endmodule

// File: rtl/expose_sequencer.sv
// expose_sequencer: frame-level initiator for the exposure timer; sequences
// erase, exposure handshake, ADC ramp and row readout with registered outputs.
module expose_sequencer
    import expose_pkg::*;
#(
    parameter int ERASE_CYCLES   = 4,
    parameter int CONVERT_CYCLES = 255,
    parameter int N_ROWS         = 2,
    parameter int TIMEOUT_MARGIN = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [EXP_W-1:0]  exposure_cycles_i,
    output logic              timer_reset_o,
    output logic              expose_enable_o,
    input  logic              expose_finished_i,
    output logic              erase_o,
    output logic              convert_o,
    output logic [RAMP_W-1:0] adc_ramp_o,
    output logic              read_valid_o,
    output logic [ROW_W-1:0]  read_row_o,
    input  logic              read_ready_i,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              timeout_err_o
);

    seq_state_t       state_q, state_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             timeout_q, timeout_d;
    logic             accept, timed_out;
    logic             erase_tc, wd_tc, ramp_tc, row_tc;
    logic [WD_W-1:0]  erase_cnt, wd_cnt;
    logic             unused_cnt;
    logic             timer_reset_q, expose_enable_q, erase_q, convert_q;
    logic             read_valid_q, busy_q, frame_done_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    state_d = start_i ? S_ERASE : S_IDLE;
            S_ERASE:   state_d = erase_tc ? S_EXPOSE : S_ERASE;
            S_EXPOSE:  state_d = expose_finished_i ? S_CONVERT : wd_tc ? S_IDLE : S_EXPOSE;
            S_CONVERT: state_d = ramp_tc ? S_READ : S_CONVERT;
            S_READ:    state_d = (read_ready_i && row_tc) ? S_DONE : S_READ;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (abort_i) state_d = S_IDLE;
    end

    // finished beats the watchdog, and abort beats both
    assign accept    = state_q == S_IDLE && start_i && !abort_i;
    assign timed_out = state_q == S_EXPOSE && !expose_finished_i && wd_tc && !abort_i;
    assign exp_d     = accept ? exposure_cycles_i : exp_q;
    assign timeout_d = accept ? 1'b0 : timed_out ? 1'b1 : timeout_q;

    seq_counter #(.W(WD_W)) u_erase (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (state_d != S_ERASE),
        .load_val_i ('0),
        .en_i       (state_q == S_ERASE),
        .tc_val_i   (WD_W'(ERASE_CYCLES - 1)),
        .cnt_o      (erase_cnt),
        .tc_o       (erase_tc)
    );

    seq_counter #(.W(WD_W)) u_watchdog (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (state_d != S_EXPOSE),
        .load_val_i ('0),
        .en_i       (state_q == S_EXPOSE),
        .tc_val_i   (wd_limit(exp_q, TIMEOUT_MARGIN)),
        .cnt_o      (wd_cnt),
        .tc_o       (wd_tc)
    );

    seq_counter #(.W(RAMP_W)) u_ramp (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (state_d != S_CONVERT),
        .load_val_i ('0),
        .en_i       (state_q == S_CONVERT),
        .tc_val_i   (RAMP_W'(CONVERT_CYCLES - 1)),
        .cnt_o      (adc_ramp_o),
        .tc_o       (ramp_tc)
    );

    seq_counter #(.W(ROW_W)) u_row (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (state_d != S_READ),
        .load_val_i ('0),
        .en_i       (state_q == S_READ && read_ready_i),
        .tc_val_i   (ROW_W'(N_ROWS - 1)),
        .cnt_o      (read_row_o),
        .tc_o       (row_tc)
    );

    assign unused_cnt = ^{erase_cnt, wd_cnt};

    // Control outputs are flopped from the next state so they line up with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_IDLE;
            exp_q           <= '0;
            timeout_q       <= 1'b0;
            timer_reset_q   <= 1'b1;
            expose_enable_q <= 1'b0;
            erase_q         <= 1'b0;
            convert_q       <= 1'b0;
            read_valid_q    <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            exp_q           <= exp_d;
            timeout_q       <= timeout_d;
            timer_reset_q   <= state_d != S_EXPOSE;
            expose_enable_q <= state_d == S_EXPOSE;
            erase_q         <= state_d == S_ERASE;
            convert_q       <= state_d == S_CONVERT;
            read_valid_q    <= state_d == S_READ;
            busy_q          <= state_d != S_IDLE;
            frame_done_q    <= state_d == S_DONE;
        end
    end

    assign timer_reset_o   = timer_reset_q;
    assign expose_enable_o = expose_enable_q;
    assign erase_o         = erase_q;
    assign convert_o       = convert_q;
    assign read_valid_o    = read_valid_q;
    assign busy_o          = busy_q;
    assign frame_done_o    = frame_done_q;
    assign timeout_err_o   = timeout_q;

endmodule

// File: tb/tb_expose_sequencer.sv
// tb_expose_sequencer: drives frames against a per-cycle expected trace built
// from the frame rules, with a behavioural exposure timer and readout sink.
module tb_expose_sequencer;

    localparam int E  = 4;
    localparam int CC = 255;
    localparam int NR = 2;
    localparam int M  = 8;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, expose_finished, read_ready;
    logic [5:0] exposure;
    logic       timer_reset, expose_enable, erase, convert, read_valid, busy, frame_done, timeout_err;
    logic [7:0] adc_ramp;
    logic [3:0] read_row;
    logic [19:0] obs;

    int checks = 0;
    int errors = 0;
    int tcnt = 0;
    int tdelay = 0;
    bit never = 1'b0;

    logic [19:0] vq[$];
    bit          rq[$];
    logic [19:0] oq[$];

    always #5 clk = ~clk;

    expose_sequencer dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .start_i           (start),
        .abort_i           (abort),
        .exposure_cycles_i (exposure),
        .timer_reset_o     (timer_reset),
        .expose_enable_o   (expose_enable),
        .expose_finished_i (expose_finished),
        .erase_o           (erase),
        .convert_o         (convert),
        .adc_ramp_o        (adc_ramp),
        .read_valid_o      (read_valid),
        .read_row_o        (read_row),
        .read_ready_i      (read_ready),
        .busy_o            (busy),
        .frame_done_o      (frame_done),
        .timeout_err_o     (timeout_err)
    );

    // exposure timer: counts enabled cycles, finishes once tdelay are done
    always @(posedge clk) tcnt <= timer_reset ? 0 : expose_enable ? tcnt + 1 : tcnt;
    assign expose_finished = expose_enable && !never && (tcnt >= tdelay);

    assign obs = {timer_reset, expose_enable, erase, convert, adc_ramp, read_valid,
                  read_row, busy, frame_done, timeout_err};

    function automatic logic [19:0] ev(input int tr, input int en, input int er, input int cv,
                                       input int ramp, input int rv, input int row,
                                       input int bz, input int fd, input int te);
        return {1'(tr), 1'(en), 1'(er), 1'(cv), 8'(ramp), 1'(rv), 4'(row), 1'(bz), 1'(fd), 1'(te)};
    endfunction

    task automatic put(input logic [19:0] v, input bit r);
        vq.push_back(v);
        rq.push_back(r);
    endtask

    // expected outputs for each cycle after the accepting edge, plus the
    // read_ready to present in that cycle
    task automatic build(input int ex, input int dly, input bit nv, input int pct, input int hold0);
        int lim;
        int n;
        bit to;
        int r;
        int k;
        bit rd;
        tdelay = dly;
        never = nv;
        vq.delete();
        rq.delete();
        lim = ex + M;
        to = nv || (dly + 1 > lim);
        n = to ? lim : dly + 1;
        repeat (E) put(ev(1,0,1,0,0,0,0,1,0,0), 1'($urandom_range(1)));
        repeat (n) put(ev(0,1,0,0,0,0,0,1,0,0), 1'($urandom_range(1)));
        if (to) begin
            put(ev(1,0,0,0,0,0,0,0,0,1), 1'($urandom_range(1)));
            return;
        end
        for (int i = 0; i < CC; i++) put(ev(1,0,0,1,i,0,0,1,0,0), 1'($urandom_range(1)));
        r = 0;
        k = 0;
        while (r < NR) begin
            rd = (k < hold0) ? 1'b0 : ($urandom_range(99) < pct);
            put(ev(1,0,0,0,0,1,r,1,0,0), rd);
            if (rd) r++;
            k++;
        end
        put(ev(1,0,0,0,0,0,0,1,1,0), 1'($urandom_range(1)));
        put(ev(1,0,0,0,0,0,0,0,0,0), 1'($urandom_range(1)));
    endtask

    // request a frame at the current negedge and record one sample per cycle
    task automatic play(input int ex, input bit hold, input int abort_at);
        oq.delete();
        start = 1'b1;
        exposure = 6'(ex);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            oq.push_back(obs);
            start = hold;
            exposure = 6'($urandom);
            read_ready = rq[i];
            abort = (i == abort_at);
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== ev(1,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL reset_async got %h exp %h", obs, ev(1,0,0,0,0,0,0,0,0,0));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== ev(1,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL reset_idle got %h exp %h", obs, ev(1,0,0,0,0,0,0,0,0,0));
        end
    endtask

    task automatic test_basic();
        build(5, 5, 0, 100, 0);
        play(5, 0, -1);
        for (int i = 0; i < vq.size(); i++) begin
            checks++;
            if (oq[i] !== vq[i]) begin
                errors++;
                $display("FAIL basic cyc %0d got %h exp %h", i, oq[i], vq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        build(3, 3, 0, 100, 3);
        play(3, 0, -1);
        for (int i = 0; i < vq.size(); i++) begin
            checks++;
            if (oq[i] !== vq[i]) begin
                errors++;
                $display("FAIL backpressure cyc %0d got %h exp %h", i, oq[i], vq[i]);
            end
        end
    endtask

    task automatic test_timeout();
        build(10, 0, 1, 100, 0);
        play(10, 0, -1);
        for (int i = 0; i < vq.size(); i++) begin
            checks++;
            if (oq[i] !== vq[i]) begin
                errors++;
                $display("FAIL timeout cyc %0d got %h exp %h", i, oq[i], vq[i]);
            end
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== ev(1,0,0,0,0,0,0,0,0,1)) begin
                errors++;
                $display("FAIL timeout_sticky got %h exp %h", obs, ev(1,0,0,0,0,0,0,0,0,1));
            end
        end
        build(2, 2, 0, 100, 0);
        play(2, 0, -1);
        for (int i = 0; i < vq.size(); i++) begin
            checks++;
            if (oq[i] !== vq[i]) begin
                errors++;
                $display("FAIL timeout_clear cyc %0d got %h exp %h", i, oq[i], vq[i]);
            end
        end
    endtask

    task automatic test_tie_and_zero();
        build(4, 4 + M - 1, 0, 100, 0);
        play(4, 0, -1);
        for (int i = 0; i < vq.size(); i++) begin
            checks++;
            if (oq[i] !== vq[i]) begin
                errors++;
                $display("FAIL tie cyc %0d got %h exp %h", i, oq[i], vq[i]);
            end
        end
        build(0, 0, 0, 100, 0);
        play(0, 0, -1);
        for (int i = 0; i < vq.size(); i++) begin
            checks++;
            if (oq[i] !== vq[i]) begin
                errors++;
                $display("FAIL zero_exp cyc %0d got %h exp %h", i, oq[i], vq[i]);
            end
        end
    endtask

    task automatic test_abort();
        int a;
        a = E + 6 + 100;
        build(5, 5, 0, 100, 0);
        while (vq.size() > a + 1) begin
            void'(vq.pop_back());
            void'(rq.pop_back());
        end
        put(ev(1,0,0,0,0,0,0,0,0,0), 1'b0);
        play(5, 0, a);
        for (int i = 0; i < vq.size(); i++) begin
            checks++;
            if (oq[i] !== vq[i]) begin
                errors++;
                $display("FAIL abort_convert cyc %0d got %h exp %h", i, oq[i], vq[i]);
            end
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== ev(1,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL abort_start got %h exp %h", obs, ev(1,0,0,0,0,0,0,0,0,0));
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_start_held();
        build(7, 3, 0, 100, 0);
        play(7, 1, -1);
        for (int i = 0; i < vq.size(); i++) begin
            checks++;
            if (oq[i] !== vq[i]) begin
                errors++;
                $display("FAIL held cyc %0d got %h exp %h", i, oq[i], vq[i]);
            end
        end
        exposure = 6'd20;
        tdelay = 60;
        @(negedge clk);
        checks++;
        if (obs !== ev(1,0,1,0,0,0,0,1,0,0)) begin
            errors++;
            $display("FAIL held_refire got %h exp %h", obs, ev(1,0,1,0,0,0,0,1,0,0));
        end
        start = 1'b0;
        repeat (E + 1) @(negedge clk);
        checks++;
        if (obs !== ev(0,1,0,0,0,0,0,1,0,0)) begin
            errors++;
            $display("FAIL held_expose got %h exp %h", obs, ev(0,1,0,0,0,0,0,1,0,0));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== ev(1,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL mid_reset got %h exp %h", obs, ev(1,0,0,0,0,0,0,0,0,0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== ev(1,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL post_reset got %h exp %h", obs, ev(1,0,0,0,0,0,0,0,0,0));
        end
    endtask

    task automatic test_random();
        int ex;
        int dly;
        bit nv;
        for (int k = 0; k < 6; k++) begin
            ex = $urandom_range(63);
            nv = ($urandom_range(3) == 0);
            dly = $urandom_range(ex + M + 2);
            build(ex, dly, nv, $urandom_range(100, 25), $urandom_range(2));
            play(ex, 0, -1);
            for (int i = 0; i < vq.size(); i++) begin
                checks++;
                if (oq[i] !== vq[i]) begin
                    errors++;
                    $display("FAIL rand%0d cyc %0d got %h exp %h", k, i, oq[i], vq[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        exposure = '0;
        read_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_tie_and_zero();
        test_abort();
        test_start_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
